// File: rtl/i2c_write_slave.sv
// I2C write-only target: START/STOP detect, 7-bit address match, ACK, byte strobe; o_data_valid 4 i_clk after SCL rise of bit 8.
// Backpressure: i_ack_en=0 NACKs data bytes; I2C_GLITCH_FILTER_EN adds a FILTER_LEN-sample SCL/SDA filter (+FILTER_LEN latency).
module i2c_write_slave #(
  parameter int unsigned            ADDR_WIDTH = 7,
  parameter int unsigned            DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  SLAVE_ADDR = 7'h3C,
  parameter int unsigned            FILTER_LEN = 3
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_scl,
  inout  wire                   io_sda,
  input  logic                  i_ack_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_start,
  output logic                  o_stop,
  output logic                  o_addr_match,
  output logic                  o_busy
);
  localparam int unsigned   CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_DATA_NACK, S_IGNORE
  } state_t;

  logic scl_s1, scl_s2, sda_s1, sda_s2, scl_f, sda_f, scl_d, sda_d;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= i_scl;  scl_s2 <= scl_s1;
      sda_s1 <= io_sda; sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] scl_cnt, sda_cnt;
  logic          scl_flt, sda_flt;

  // Output follows the input only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      scl_cnt <= '0; sda_cnt <= '0;
      scl_flt <= 1'b1; sda_flt <= 1'b1;
    end else begin
      if (scl_s2 == scl_flt) scl_cnt <= '0;
      else if (scl_cnt == FW'(FILTER_LEN - 1)) begin scl_flt <= scl_s2; scl_cnt <= '0; end
      else scl_cnt <= scl_cnt + FW'(1);
      if (sda_s2 == sda_flt) sda_cnt <= '0;
      else if (sda_cnt == FW'(FILTER_LEN - 1)) begin sda_flt <= sda_s2; sda_cnt <= '0; end
      else sda_cnt <= sda_cnt + FW'(1);
    end
  end
  assign scl_f = scl_flt;
  assign sda_f = sda_flt;
`else
  logic unused_cfg;
  assign unused_cfg = (FILTER_LEN == 0);
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      scl_d <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f; sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_f & ~scl_d;
  assign scl_fall  = ~scl_f &  scl_d;
  assign start_det =  scl_f &  scl_d &  sda_d & ~sda_f;
  assign stop_det  =  scl_f &  scl_d & ~sda_d &  sda_f;

  state_t                state_q, state_nxt;
  logic [CW-1:0]         cnt_q, cnt_nxt;
  logic [DATA_WIDTH-1:0] sh_q, sh_nxt, data_nxt, byte_full;
  logic                  drive_q, drive_nxt, ackph_q, ackph_nxt, busy_nxt;
  logic                  dv_set, dv_pend, start_nxt, stop_nxt, match_nxt;

  assign byte_full = {sh_q[DATA_WIDTH-2:0], sda_f};

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    sh_nxt    = sh_q;
    drive_nxt = drive_q;
    ackph_nxt = ackph_q;
    busy_nxt  = o_busy;
    data_nxt  = o_data;
    dv_set    = 1'b0;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;
    match_nxt = 1'b0;
    if (stop_det) begin
      state_nxt = S_IDLE; cnt_nxt = '0; sh_nxt = '0;
      drive_nxt = 1'b0; ackph_nxt = 1'b0; busy_nxt = 1'b0; stop_nxt = 1'b1;
    end else if (start_det) begin
      state_nxt = S_ADDR; cnt_nxt = '0; sh_nxt = '0;
      drive_nxt = 1'b0; ackph_nxt = 1'b0; start_nxt = 1'b1;
    end else begin
      case (state_q)
        S_ADDR, S_DATA: if (scl_rise) begin
          sh_nxt = byte_full;
          if (cnt_q != BIT_LAST) begin
            cnt_nxt = cnt_q + CW'(1);
          end else if (state_q == S_ADDR) begin
            if (byte_full[DATA_WIDTH-1 -: ADDR_WIDTH] == SLAVE_ADDR && !byte_full[0]) begin
              state_nxt = S_ADDR_ACK; match_nxt = 1'b1; busy_nxt = 1'b1;
            end else begin
              state_nxt = S_IGNORE; busy_nxt = 1'b0;
            end
          end else if (i_ack_en) begin
            state_nxt = S_DATA_ACK; data_nxt = byte_full; dv_set = 1'b1;
          end else begin
            state_nxt = S_DATA_NACK;
          end
        end
        // First SCL fall starts the ACK bit, second one ends it.
        S_ADDR_ACK, S_DATA_ACK, S_DATA_NACK: if (scl_fall) begin
          if (!ackph_q) begin
            ackph_nxt = 1'b1;
            drive_nxt = (state_q != S_DATA_NACK);
          end else begin
            ackph_nxt = 1'b0; drive_nxt = 1'b0; cnt_nxt = '0; sh_nxt = '0;
            state_nxt = (state_q == S_DATA_NACK) ? S_IGNORE : S_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= S_IDLE; cnt_q <= '0; sh_q <= '0;
      drive_q <= 1'b0; ackph_q <= 1'b0; o_busy <= 1'b0;
      o_data <= '0; dv_pend <= 1'b0; o_data_valid <= 1'b0;
      o_start <= 1'b0; o_stop <= 1'b0; o_addr_match <= 1'b0;
    end else begin
      state_q <= state_nxt; cnt_q <= cnt_nxt; sh_q <= sh_nxt;
      drive_q <= drive_nxt; ackph_q <= ackph_nxt; o_busy <= busy_nxt;
      o_data <= data_nxt; dv_pend <= dv_set; o_data_valid <= dv_pend;
      o_start <= start_nxt; o_stop <= stop_nxt; o_addr_match <= match_nxt;
    end
  end

  assign io_sda = drive_q ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_i2c_write_slave.sv
// Bench for i2c_write_slave: bit-banged I2C master, pulse monitor and received-byte scoreboard.
module tb_i2c_write_slave;
  localparam int Q = 10;

  logic       clk = 1'b0, arst_n = 1'b0, scl = 1'b1, m_low = 1'b0, ack_en = 1'b1;
  wire        sda;
  logic [7:0] o_data;
  logic       dv, st, sp, am, busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_write_slave dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_scl(scl), .io_sda(sda), .i_ack_en(ack_en),
    .o_data(o_data), .o_data_valid(dv), .o_start(st), .o_stop(sp),
    .o_addr_match(am), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int vec = 0, mis = 0;
  int n_start = 0, n_stop = 0, n_match = 0, n_valid = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int rx_rd = 0;

  always @(negedge clk) begin
    if (dv) begin rx_q.push_back(o_data); n_valid <= n_valid + 1; end
    if (st) n_start <= n_start + 1;
    if (sp) n_stop  <= n_stop + 1;
    if (am) n_match <= n_match + 1;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic i2c_start;
    m_low = 1'b0; clks(Q); scl = 1'b1; clks(Q); m_low = 1'b1; clks(Q); scl = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop;
    m_low = 1'b1; clks(Q); scl = 1'b1; clks(Q); m_low = 1'b0; clks(2*Q);
  endtask

  task automatic i2c_bit(input logic b);
    m_low = ~b; clks(Q); scl = 1'b1; clks(2*Q); scl = 1'b0; clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
    m_low = 1'b0; clks(Q); scl = 1'b1; clks(Q);
    ack = (sda === 1'b0);
    clks(Q); scl = 1'b0; clks(Q);
  endtask

  task automatic test_reset;
    arst_n = 1'b0; clks(3); @(negedge clk);
    vec++; if (o_data !== 8'h00) begin mis++; $display("FAIL reset_data: got %h want 00", o_data); end
    vec++; if ({dv, st, sp, am, busy} !== 5'b0) begin mis++; $display("FAIL reset_flags: got %b want 00000", {dv, st, sp, am, busy}); end
    vec++; if (sda !== 1'b1) begin mis++; $display("FAIL reset_sda: got %b want 1 (released)", sda); end
    arst_n = 1'b1; clks(5);
  endtask

  task automatic test_basic_write;
    int s_st, s_sp, s_am, s_dv; logic ack_a, ack_d; logic [7:0] e;
    s_st = n_start; s_sp = n_stop; s_am = n_match; s_dv = n_valid;
    i2c_start; send_byte(8'h78, ack_a);
    @(negedge clk);
    vec++; if (busy !== 1'b1) begin mis++; $display("FAIL t1_busy: got %b want 1", busy); end
    exp_q.push_back(8'hA5); send_byte(8'hA5, ack_d); i2c_stop;
    vec++; if (ack_a !== 1'b1) begin mis++; $display("FAIL t1_addr_ack: got %b want 1", ack_a); end
    vec++; if (ack_d !== 1'b1) begin mis++; $display("FAIL t1_data_ack: got %b want 1", ack_d); end
    vec++; if (n_start - s_st != 1) begin mis++; $display("FAIL t1_start: got %0d want 1", n_start - s_st); end
    vec++; if (n_stop - s_sp != 1) begin mis++; $display("FAIL t1_stop: got %0d want 1", n_stop - s_sp); end
    vec++; if (n_match - s_am != 1) begin mis++; $display("FAIL t1_match: got %0d want 1", n_match - s_am); end
    vec++; if (n_valid - s_dv != 1) begin mis++; $display("FAIL t1_valid: got %0d want 1", n_valid - s_dv); end
    vec++; if (busy !== 1'b0) begin mis++; $display("FAIL t1_busy_stop: got %b want 0", busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (rx_rd >= rx_q.size()) begin mis++; $display("FAIL t1_data: got none want %h", e); end
      else begin if (rx_q[rx_rd] !== e) begin mis++; $display("FAIL t1_data: got %h want %h", rx_q[rx_rd], e); end rx_rd++; end
    end
  endtask

  task automatic test_wrong_addr(input logic [7:0] a, input string nm);
    int s_am, s_dv; logic ack_a, ack_d;
    s_am = n_match; s_dv = n_valid;
    i2c_start; send_byte(a, ack_a); send_byte(8'h55, ack_d);
    @(negedge clk);
    vec++; if (busy !== 1'b0) begin mis++; $display("FAIL %s_busy: got %b want 0", nm, busy); end
    i2c_stop;
    vec++; if (ack_a !== 1'b0) begin mis++; $display("FAIL %s_addr_nack: got ack=%b want 0", nm, ack_a); end
    vec++; if (ack_d !== 1'b0) begin mis++; $display("FAIL %s_data_nack: got ack=%b want 0", nm, ack_d); end
    vec++; if (n_match - s_am != 0) begin mis++; $display("FAIL %s_match: got %0d want 0", nm, n_match - s_am); end
    vec++; if (n_valid - s_dv != 0) begin mis++; $display("FAIL %s_valid: got %0d want 0", nm, n_valid - s_dv); end
  endtask

  task automatic test_ack_en;
    int s_dv; logic a0, a1, a2, a3; logic [7:0] e;
    s_dv = n_valid;
    i2c_start; send_byte(8'h78, a0);
    ack_en = 1'b1; exp_q.push_back(8'h00); send_byte(8'h00, a1);
    ack_en = 1'b0; send_byte(8'hFF, a2);
    ack_en = 1'b1; send_byte(8'h80, a3);
    i2c_stop;
    vec++; if ({a0, a1, a2, a3} !== 4'b1100) begin mis++; $display("FAIL t4_acks: got %b want 1100", {a0, a1, a2, a3}); end
    vec++; if (n_valid - s_dv != 1) begin mis++; $display("FAIL t4_valid: got %0d want 1", n_valid - s_dv); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (rx_rd >= rx_q.size()) begin mis++; $display("FAIL t4_data: got none want %h", e); end
      else begin if (rx_q[rx_rd] !== e) begin mis++; $display("FAIL t4_data: got %h want %h", rx_q[rx_rd], e); end rx_rd++; end
    end
  endtask

  task automatic test_repeated_start;
    int s_st, s_am, s_dv; logic a0, a1, a2; logic [7:0] e;
    s_st = n_start; s_am = n_match; s_dv = n_valid;
    i2c_start; send_byte(8'h78, a0);
    i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b1); i2c_bit(1'b0);
    i2c_start; send_byte(8'h78, a1);
    exp_q.push_back(8'h11); send_byte(8'h11, a2);
    i2c_stop;
    vec++; if ({a0, a1, a2} !== 3'b111) begin mis++; $display("FAIL t5_acks: got %b want 111", {a0, a1, a2}); end
    vec++; if (n_start - s_st != 2) begin mis++; $display("FAIL t5_start: got %0d want 2", n_start - s_st); end
    vec++; if (n_match - s_am != 2) begin mis++; $display("FAIL t5_match: got %0d want 2", n_match - s_am); end
    vec++; if (n_valid - s_dv != 1) begin mis++; $display("FAIL t5_valid: got %0d want 1", n_valid - s_dv); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (rx_rd >= rx_q.size()) begin mis++; $display("FAIL t5_data: got none want %h", e); end
      else begin if (rx_q[rx_rd] !== e) begin mis++; $display("FAIL t5_data: got %h want %h", rx_q[rx_rd], e); end rx_rd++; end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] a; logic a0, a1; logic [7:0] e;
    a = 8'h78;
    i2c_start;
    for (int i = 7; i >= 0; i--) i2c_bit(a[i]);
    m_low = 1'b0; clks(2); @(negedge clk);
    vec++; if (sda !== 1'b0) begin mis++; $display("FAIL t6_ack_drive: got %b want 0", sda); end
    arst_n = 1'b0; #1;
    vec++; if (sda !== 1'b1) begin mis++; $display("FAIL t6_sda_release: got %b want 1", sda); end
    vec++; if ({o_data, busy, am, dv} !== 11'b0) begin mis++; $display("FAIL t6_reset_outs: got data=%h busy=%b match=%b valid=%b want 0", o_data, busy, am, dv); end
    clks(2); scl = 1'b1; clks(Q); scl = 1'b0; clks(Q);
    arst_n = 1'b1; clks(Q);
    i2c_stop;
    i2c_start; send_byte(8'h78, a0);
`ifdef I2C_GLITCH_FILTER_EN
    @(posedge clk); scl = 1'b1; @(posedge clk); scl = 1'b0; clks(Q);
`endif
    exp_q.push_back(8'h5A); send_byte(8'h5A, a1);
    i2c_stop;
    vec++; if ({a0, a1} !== 2'b11) begin mis++; $display("FAIL t6_acks: got %b want 11", {a0, a1}); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (rx_rd >= rx_q.size()) begin mis++; $display("FAIL t6_data: got none want %h", e); end
      else begin if (rx_q[rx_rd] !== e) begin mis++; $display("FAIL t6_data: got %h want %h", rx_q[rx_rd], e); end rx_rd++; end
    end
    vec++; if (rx_rd != rx_q.size()) begin mis++; $display("FAIL extra_data: got %0d strobes want %0d", rx_q.size(), rx_rd); end
  endtask

  initial begin
    test_reset;
    test_basic_write;
    test_wrong_addr(8'h7A, "t2");
    test_wrong_addr(8'h79, "t3");
    test_ack_en;
    test_repeated_start;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
